time_keeper: RTL and testbench

// - Running time-of-day counter directly downstream of the time-setting stage.
// - While the mode bus reads SET_TIME (3'b010), it holds and loads the hours/minutes/seconds being set.
// - Otherwise it counts HH:MM:SS in 24 h format from a prescaled 1 Hz tick.
// - Also flags the alarm match that the display and buzzer stages consume.

---
 rtl/time_keeper_pkg.sv | 28 ++
 rtl/time_keeper_if.sv | 35 +++
 rtl/time_keeper_tick_gen.sv | 36 +++
 rtl/time_keeper.sv | 106 ++++++++++
 tb/tb_time_keeper.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/time_keeper_pkg.sv
// Shared alarm-clock constants: mode-bus codes, field widths, limits and the
// range-clamp helpers used when loading a time from the set stage.
package time_keeper_pkg;

  localparam int HR_W = 5;
  localparam int MS_W = 6;

  localparam logic [MS_W-1:0] MAX_SEC = 6'd59;
  localparam logic [MS_W-1:0] MAX_MIN = 6'd59;
  localparam logic [HR_W-1:0] MAX_HR  = 5'd23;

  typedef enum logic [2:0] {
    MODE_NORMAL     = 3'b000,
    MODE_SET_ALARM  = 3'b001,
    MODE_SET_TIME   = 3'b010,
    MODE_ALARM_VIEW = 3'b011
  } mode_e;

  // Out-of-range values from the set stage load as zero rather than wrapping.
  function automatic logic [HR_W-1:0] clamp_hr(input logic [HR_W-1:0] h);
    return (h > MAX_HR) ? '0 : h;
  endfunction

  function automatic logic [MS_W-1:0] clamp_ms(input logic [MS_W-1:0] v);
    return (v > MAX_SEC) ? '0 : v;
  endfunction

endpackage

// File: rtl/time_keeper_if.sv
// Bus between the mode/set/alarm stages and the time keeper; the master side
// drives mode and set/alarm values, the slave side returns time and pulses.
interface time_keeper_if;
  import time_keeper_pkg::*;

  logic [2:0]      state;
  logic [HR_W-1:0] set_hours;
  logic [MS_W-1:0] set_minutes;
  logic [MS_W-1:0] set_seconds;
  logic            alarm_en;
  logic [HR_W-1:0] alarm_hours;
  logic [MS_W-1:0] alarm_min;

  logic [HR_W-1:0] hours;
  logic [MS_W-1:0] minutes;
  logic [MS_W-1:0] seconds;
  logic            sec_pulse;
  logic            day_wrap;
  logic            alarm_fire;

  // No handshake: inputs are level values sampled every clock, and the three
  // pulse outputs are single-cycle strobes with no back-pressure.
  modport master (
    output state, set_hours, set_minutes, set_seconds,
    output alarm_en, alarm_hours, alarm_min,
    input  hours, minutes, seconds, sec_pulse, day_wrap, alarm_fire
  );

  modport slave (
    input  state, set_hours, set_minutes, set_seconds,
    input  alarm_en, alarm_hours, alarm_min,
    output hours, minutes, seconds, sec_pulse, day_wrap, alarm_fire
  );

endinterface

// File: rtl/time_keeper_tick_gen.sv
// Prescaler producing one terminal-count cycle every CLK_HZ enabled clocks;
// clr forces the count back to zero and suppresses tc.
module time_keeper_tick_gen #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] TC_VAL = PW'(CLK_HZ - 1);

  logic [PW-1:0] r_presc;
  logic          w_at_tc;

  assign w_at_tc = (r_presc == TC_VAL);
  assign tc      = en && !clr && w_at_tc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
    end else if (clr) begin
      r_presc <= '0;
    end else if (en) begin
      if (w_at_tc) begin
        r_presc <= '0;
      end else begin
        r_presc <= r_presc + PW'(1);
      end
    end
  end

endmodule

// File: rtl/time_keeper.sv
// 24 h HH:MM:SS counter: loads (clamped) set values while the mode bus reads
// SET_STATE, otherwise advances once per prescaled second and flags alarms.
module time_keeper
  import time_keeper_pkg::*;
#(
  parameter int         CLK_HZ    = 100_000_000,
  parameter logic [2:0] SET_STATE = MODE_SET_TIME
) (
  input  logic          clk,
  input  logic          rst,
  time_keeper_if.slave  bus
);

  logic [HR_W-1:0] r_hr;
  logic [MS_W-1:0] r_min;
  logic [MS_W-1:0] r_sec;
  logic            r_sec_pulse;
  logic            r_day_wrap;
  logic            r_alarm_fire;

  logic            w_set;
  logic            w_tc;
  logic [HR_W-1:0] w_hr_n;
  logic [MS_W-1:0] w_min_n;
  logic [MS_W-1:0] w_sec_n;
  logic            w_day;
  logic            w_alarm_valid;
  logic            w_alarm_hit;

  assign w_set = (bus.state == SET_STATE);

  time_keeper_tick_gen #(
    .CLK_HZ (CLK_HZ)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .clr (w_set),
    .en  (!w_set),
    .tc  (w_tc)
  );

  // Next time after one second; carries ripple through all fields in one edge.
  always_comb begin
    w_sec_n = r_sec + MS_W'(1);
    w_min_n = r_min;
    w_hr_n  = r_hr;
    w_day   = 1'b0;
    if (r_sec == MAX_SEC) begin
      w_sec_n = '0;
      if (r_min == MAX_MIN) begin
        w_min_n = '0;
        if (r_hr == MAX_HR) begin
          w_hr_n = '0;
          w_day  = 1'b1;
        end else begin
          w_hr_n = r_hr + HR_W'(1);
        end
      end else begin
        w_min_n = r_min + MS_W'(1);
      end
    end
  end

  // The alarm matches only on the tick that rolls seconds over to zero,
  // so it fires once per day and never from a SET-mode load.
  assign w_alarm_valid = (bus.alarm_hours <= MAX_HR) && (bus.alarm_min <= MAX_MIN);
  assign w_alarm_hit   = bus.alarm_en && w_alarm_valid && (w_sec_n == '0) &&
                         (w_hr_n == bus.alarm_hours) && (w_min_n == bus.alarm_min);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hr         <= '0;
      r_min        <= '0;
      r_sec        <= '0;
      r_sec_pulse  <= 1'b0;
      r_day_wrap   <= 1'b0;
      r_alarm_fire <= 1'b0;
    end else if (w_set) begin
      r_hr         <= clamp_hr(bus.set_hours);
      r_min        <= clamp_ms(bus.set_minutes);
      r_sec        <= clamp_ms(bus.set_seconds);
      r_sec_pulse  <= 1'b0;
      r_day_wrap   <= 1'b0;
      r_alarm_fire <= 1'b0;
    end else if (w_tc) begin
      r_hr         <= w_hr_n;
      r_min        <= w_min_n;
      r_sec        <= w_sec_n;
      r_sec_pulse  <= 1'b1;
      r_day_wrap   <= w_day;
      r_alarm_fire <= w_alarm_hit;
    end else begin
      r_sec_pulse  <= 1'b0;
      r_day_wrap   <= 1'b0;
      r_alarm_fire <= 1'b0;
    end
  end

  assign bus.hours      = r_hr;
  assign bus.minutes    = r_min;
  assign bus.seconds    = r_sec;
  assign bus.sec_pulse  = r_sec_pulse;
  assign bus.day_wrap   = r_day_wrap;
  assign bus.alarm_fire = r_alarm_fire;

endmodule

// File: tb/tb_time_keeper.sv
// Directed bench for time_keeper at CLK_HZ = 4: reset, load/clamp, carries,
// day wrap, alarm, SET/tick collision and mid-second reset.
module tb_time_keeper;
  import time_keeper_pkg::*;

  logic clk;
  logic rst;

  int n_assert;
  int n_fail;
  int cnt_sp;
  int cnt_dw;
  int cnt_af;
  int first_sp;
  int last_sp;

  time_keeper_if u_if ();

  time_keeper #(
    .CLK_HZ    (4),
    .SET_STATE (3'b010)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_time(input string tag, input int h, input int m, input int s);
    check({tag, "_hr"},  32'(u_if.hours),   32'(h));
    check({tag, "_min"}, 32'(u_if.minutes), 32'(m));
    check({tag, "_sec"}, 32'(u_if.seconds), 32'(s));
  endtask

  task automatic clear_counts();
    cnt_sp = 0;
    cnt_dw = 0;
    cnt_af = 0;
  endtask

  // Advance n clocks; sample 1 time unit after each rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (u_if.sec_pulse === 1'b1)  cnt_sp++;
      if (u_if.day_wrap === 1'b1)   cnt_dw++;
      if (u_if.alarm_fire === 1'b1) cnt_af++;
    end
  endtask

  // One SET-mode cycle loading h:m:s, then return to normal counting.
  task automatic load(input int h, input int m, input int s);
    u_if.state       = MODE_SET_TIME;
    u_if.set_hours   = HR_W'(h);
    u_if.set_minutes = MS_W'(m);
    u_if.set_seconds = MS_W'(s);
    step(1);
    u_if.state = MODE_NORMAL;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    clear_counts();
    rst              = 1'b1;
    u_if.state       = MODE_NORMAL;
    u_if.set_hours   = '0;
    u_if.set_minutes = '0;
    u_if.set_seconds = '0;
    u_if.alarm_en    = 1'b0;
    u_if.alarm_hours = '0;
    u_if.alarm_min   = '0;

    // Reset state
    step(3);
    check_time("rst", 0, 0, 0);
    check("rst_sp", 32'(u_if.sec_pulse),  0);
    check("rst_dw", 32'(u_if.day_wrap),   0);
    check("rst_af", 32'(u_if.alarm_fire), 0);

    // Run 8 cycles: increments on cycles 4 and 8
    rst = 1'b0;
    clear_counts();
    first_sp = -1;
    last_sp  = -1;
    for (int i = 1; i <= 8; i++) begin
      step(1);
      if (u_if.sec_pulse === 1'b1) begin
        if (first_sp < 0) first_sp = i;
        last_sp = i;
      end
    end
    check_time("run8", 0, 0, 2);
    check("run8_pulses", 32'(cnt_sp), 2);
    check("run8_first",  32'(first_sp), 4);
    check("run8_gap",    32'(last_sp - first_sp), 4);

    // Set/load 13:45:58, held during set
    u_if.state       = MODE_SET_TIME;
    u_if.set_hours   = 5'd13;
    u_if.set_minutes = 6'd45;
    u_if.set_seconds = 6'd58;
    clear_counts();
    step(2);
    check_time("set_hold", 13, 45, 58);
    check("set_no_sp", 32'(cnt_sp), 0);
    u_if.state = MODE_NORMAL;
    step(3);
    check_time("exit_3", 13, 45, 58);
    step(1);
    check_time("exit_4", 13, 45, 59);
    check("exit_4_sp", 32'(u_if.sec_pulse), 1);
    step(4);
    check_time("exit_8", 13, 46, 0);

    // Clamp out-of-range set values
    u_if.state       = MODE_SET_TIME;
    u_if.set_hours   = 5'd27;
    u_if.set_minutes = 6'd61;
    u_if.set_seconds = 6'd30;
    step(1);
    check_time("clamp", 0, 0, 30);

    // Hour carry without day wrap
    load(9, 59, 59);
    clear_counts();
    step(4);
    check_time("hr_carry", 10, 0, 0);
    check("hr_carry_dw", 32'(cnt_dw), 0);

    // Day wrap
    load(23, 59, 59);
    clear_counts();
    step(3);
    check_time("wrap_pre", 23, 59, 59);
    step(1);
    check_time("wrap", 0, 0, 0);
    check("wrap_dw", 32'(u_if.day_wrap), 1);
    step(1);
    check("wrap_dw_after", 32'(u_if.day_wrap), 0);
    check("wrap_dw_count", 32'(cnt_dw), 1);

    // Alarm armed at 07:30
    u_if.alarm_en    = 1'b1;
    u_if.alarm_hours = 5'd7;
    u_if.alarm_min   = 6'd30;
    load(7, 29, 59);
    clear_counts();
    step(3);
    check("alarm_early", 32'(cnt_af), 0);
    step(1);
    check_time("alarm_time", 7, 30, 0);
    check("alarm_fire", 32'(u_if.alarm_fire), 1);
    step(1);
    check("alarm_fire_after", 32'(u_if.alarm_fire), 0);
    step(4);
    check("alarm_once", 32'(cnt_af), 1);

    // Alarm disarmed
    u_if.alarm_en = 1'b0;
    load(7, 29, 59);
    clear_counts();
    step(5);
    check_time("alarm_off_time", 7, 30, 0);
    check("alarm_off", 32'(cnt_af), 0);

    // Loading the alarm time directly does not fire
    u_if.alarm_en = 1'b1;
    clear_counts();
    load(7, 30, 0);
    step(4);
    check_time("alarm_load_time", 7, 30, 1);
    check("alarm_load", 32'(cnt_af), 0);

    // Invalid alarm minute never fires
    u_if.alarm_min = 6'd60;
    load(7, 59, 59);
    clear_counts();
    step(5);
    check("alarm_invalid", 32'(cnt_af), 0);
    u_if.alarm_min = 6'd30;

    // Collision: enter SET on the cycle the prescaler is at terminal count
    load(12, 0, 0);
    step(3);
    u_if.state       = MODE_SET_TIME;
    u_if.set_hours   = 5'd12;
    u_if.set_minutes = 6'd0;
    u_if.set_seconds = 6'd0;
    clear_counts();
    step(1);
    check_time("collide", 12, 0, 0);
    check("collide_sp", 32'(cnt_sp), 0);
    u_if.state = MODE_NORMAL;
    step(3);
    check_time("collide_resume_3", 12, 0, 0);
    step(1);
    check_time("collide_resume_4", 12, 0, 1);

    // Reset mid-second at 12:00:03
    step(8);
    check_time("pre_rst", 12, 0, 3);
    step(2);
    rst = 1'b1;
    #1;
    check_time("rst_async", 0, 0, 0);
    clear_counts();
    step(2);
    rst = 1'b0;
    step(1);
    check_time("rst_release", 0, 0, 0);
    check("rst_release_pulses", 32'(cnt_sp + cnt_dw + cnt_af), 0);
    step(3);
    check_time("rst_restart", 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
